// File: rtl/i2c_target_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_if
// Brief    : User-side and SCL signals of the I2C target; SDA stays a pad port.
// Revision : 1.0
// ============================================================================
interface i2c_target_if;
    logic       SCL;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       busy;

    modport slave (
        input  SCL,
        input  tx_data,
        output rx_data,
        output rx_valid,
        output tx_req,
        output busy
    );

    modport master (
        output SCL,
        output tx_data,
        input  rx_data,
        input  rx_valid,
        input  tx_req,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Brief    : Oversampled I2C target: fixed address, write strobe, read fetch.
// Revision : 1.0
// ============================================================================
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  wire         clk,
    input  wire         rst_n,
    i2c_target_if.slave bus,
    inout  wire         SDA
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_WR_DATA   = 3'd3,
        S_WR_ACK    = 3'd4,
        S_RD_DATA   = 3'd5,
        S_RD_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_t;

    // [0] first stage, [1] synchronized value, [2] history for edge detection
    logic [2:0] r_scl_sync;
    logic [2:0] r_sda_sync;
    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_rw;
    logic       r_phase;
    logic       r_sda_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;
    logic       r_busy;

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], bus.SCL};
            r_sda_sync <= {r_sda_sync[1:0], SDA};
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise =  r_scl_sync[1] & ~r_scl_sync[2];
    assign w_scl_fall = ~r_scl_sync[1] &  r_scl_sync[2];
    assign w_start    = w_scl & ~r_sda_sync[1] &  r_sda_sync[2];
    assign w_stop     = w_scl &  r_sda_sync[1] & ~r_sda_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'h00;
            r_bitcnt   <= 3'd0;
            r_rw       <= 1'b0;
            r_phase    <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            if (w_start || w_stop) begin
                r_state  <= w_start ? S_ADDR : S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_bitcnt <= 3'd0;
                r_phase  <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_rw <= w_sda;
                                if (r_shift[6:0] == ADDR && r_shift[6:0] != 7'h00) begin
                                    r_state <= S_ADDR_ACK;
                                    r_busy  <= 1'b1;
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end
                        end
                    end
                    // r_phase marks the ACK slot: set on the fall that opens it
                    S_ADDR_ACK, S_WR_ACK: begin
                        if (w_scl_rise && r_phase && r_state == S_ADDR_ACK && r_rw) begin
                            r_tx_req <= 1'b1;
                        end
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_phase  <= 1'b1;
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_shift  <= bus.tx_data;
                                    r_sda_oe <= ~bus.tx_data[7];
                                    r_state  <= S_RD_DATA;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= S_WR_DATA;
                                end
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_rx_data  <= {r_shift[6:0], w_sda};
                                r_rx_valid <= 1'b1;
                                r_state    <= S_WR_ACK;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 3'd0) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_RD_ACK;
                            end else begin
                                r_sda_oe <= ~r_shift[3'd7 - r_bitcnt];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise && !r_phase) begin
                            if (w_sda) begin
                                r_state <= S_WAIT_STOP;
                            end else begin
                                r_tx_req <= 1'b1;
                                r_phase  <= 1'b1;
                            end
                        end else if (w_scl_fall && r_phase) begin
                            r_phase  <= 1'b0;
                            r_shift  <= bus.tx_data;
                            r_sda_oe <= ~bus.tx_data[7];
                            r_state  <= S_RD_DATA;
                        end
                    end
                    S_IDLE, S_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign SDA          = r_sda_oe ? 1'b0 : 1'bz;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.tx_req   = r_tx_req;
    assign bus.busy     = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target
// Brief    : Bit-banged I2C master with scoreboard for the i2c_target block.
// Revision : 1.0
// ============================================================================
module tb_i2c_target;
    localparam logic [6:0] c_addr = 7'h42;
    localparam int         c_q    = 10;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic r_sda_rel = 1'b1;
    wire  SDA;

    int n_vec   = 0;
    int n_err   = 0;
    int n_txreq = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] tx_src[$];
    logic [7:0] pay[$];

    i2c_target_if bus();

    i2c_target #(.ADDR(c_addr)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .SDA   (SDA)
    );

    assign SDA = r_sda_rel ? 1'bz : 1'b0;
    pullup (SDA);

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for write strobes, and user-side responder for reads
    always @(negedge clk) begin
        if (rst_n && bus.rx_valid) begin
            if (exp_rx.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rx_valid: unexpected strobe with rx_data %0h", bus.rx_data);
            end else begin
                chk("rx_data", bus.rx_data, exp_rx.pop_front());
            end
        end
        if (rst_n && bus.tx_req) begin
            n_txreq++;
            if (tx_src.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_req: unexpected request, none expected");
            end else begin
                bus.tx_data = tx_src.pop_front();
            end
        end
    end

    task automatic wait_q();
        repeat (c_q) @(negedge clk);
    endtask

    task automatic bus_start();
        r_sda_rel = 1'b1; wait_q();
        bus.SCL   = 1'b1; wait_q();
        r_sda_rel = 1'b0; wait_q();
        bus.SCL   = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        r_sda_rel = 1'b0; wait_q();
        bus.SCL   = 1'b1; wait_q();
        r_sda_rel = 1'b1; wait_q();
    endtask

    task automatic clock_bit(input logic b, output logic s);
        r_sda_rel = b;    wait_q();
        bus.SCL   = 1'b1; wait_q();
        s = SDA;          wait_q();
        bus.SCL   = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic       s;
        logic [7:0] v;
        v = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            v[i] = s;
        end
        clock_bit(~ack, s);
        d = v;
    endtask

    // Reference: a target at c_addr ACKs its address and every written byte,
    // delivers written bytes in order, and returns one tx_data per request.
    task automatic transaction(input logic [6:0] a, input logic rw, input logic do_stop);
        logic       match, ack;
        logic [7:0] got, exp_rd[$];
        int         req0;
        match = (a == c_addr) && (a != 7'h00);
        req0  = n_txreq;
        if (rw && match) begin
            foreach (pay[k]) begin
                tx_src.push_back(pay[k]);
                exp_rd.push_back(pay[k]);
            end
        end
        bus_start();
        write_byte({a, rw}, ack);
        chk("addr_ack", ack, match);
        chk("busy_after_addr", bus.busy, match);
        if (rw && match) begin
            for (int k = 0; k < exp_rd.size(); k++) begin
                read_byte(k < exp_rd.size() - 1, got);
                chk("rd_data", got, exp_rd[k]);
            end
            chk("sda_released_after_nack", SDA, 1);
        end else if (!rw) begin
            foreach (pay[k]) begin
                if (match) exp_rx.push_back(pay[k]);
                write_byte(pay[k], ack);
                chk("data_ack", ack, match);
            end
        end
        if (do_stop) begin
            bus_stop();
            chk("busy_after_stop", bus.busy, 0);
            chk("tx_req_count", n_txreq - req0, (rw && match) ? exp_rd.size() : 0);
        end
    endtask

    initial begin
        logic       ack, s;
        logic [6:0] a;
        int         req0;
        bus.SCL     = 1'b1;
        bus.tx_data = 8'h00;
        repeat (5) @(negedge clk);
        chk("reset_rx_data", bus.rx_data, 8'h00);
        chk("reset_rx_valid", bus.rx_valid, 0);
        chk("reset_tx_req", bus.tx_req, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_sda", SDA, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        pay = '{8'hA5, 8'h3C};        transaction(7'h42, 1'b0, 1'b1);
        pay = '{8'h5A, 8'hC3};        transaction(7'h42, 1'b1, 1'b1);
        pay = '{8'hFF};               transaction(7'h48, 1'b0, 1'b1);
        pay = '{8'h12};               transaction(7'h00, 1'b0, 1'b1);

        // Partial write byte, then repeated START into a read
        bus_start();
        write_byte(8'h84, ack);
        chk("partial_addr_ack", ack, 1);
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s);
        pay = '{8'h69};               transaction(7'h42, 1'b1, 1'b1);

        for (int t = 0; t < 14; t++) begin
            a = ($urandom_range(0, 3) != 0) ? c_addr : 7'($urandom);
            pay.delete();
            for (int k = 0; k < $urandom_range(1, 3); k++) pay.push_back(8'($urandom));
            transaction(a, 1'($urandom), 1'b1);
        end

        // Reset while the target is pulling SDA low in the middle of a read byte
        tx_src.push_back(8'h00);
        bus_start();
        write_byte(8'h85, ack);
        chk("rst_addr_ack", ack, 1);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        r_sda_rel = 1'b1;
        chk("sda_driven_bit3", SDA, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("sda_async_release", SDA, 1);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_req", bus.tx_req, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_q();
        bus.SCL = 1'b1;
        wait_q();
        pay = '{8'hE7, 8'h18};        transaction(7'h42, 1'b0, 1'b1);

        // START immediately followed by STOP, no SCL pulses
        req0 = n_txreq;
        r_sda_rel = 1'b0; wait_q();
        r_sda_rel = 1'b1; wait_q();
        chk("start_stop_busy", bus.busy, 0);
        chk("start_stop_tx_req", n_txreq - req0, 0);
        pay = '{8'h3D};               transaction(7'h42, 1'b0, 1'b1);

        wait_q();
        chk("rx_queue_drained", exp_rx.size(), 0);
        chk("tx_queue_drained", tx_src.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) responder for the other end of the bus driven by our I2C master `driver`. It watches the master's `SCL`/`SDA`, detects START/STOP, matches a fixed 7-bit address, and acknowledges it. Bytes the master writes are delivered on a one-cycle strobe. Bytes the master reads are fetched from the user logic through a request/data handshake. The block oversamples the bus with a local system clock, uses open-drain SDA only, and never stretches the clock.

## Interface

Parameters:
- `ADDR`, 7'h42: 7-bit target address this block answers to.

Ports:
- `clk`, input, 1: system clock. Must be ≥ 20× the SCL rate; 50 MHz for 400 kHz SCL.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `SCL`, input, 1: bus clock from the master. Target never drives it.
- `SDA`, inout, 1: bus data, open-drain. Driven 1'b0 or 1'bz only.
- `rx_data`, output, 8: last byte written by the master.
- `rx_valid`, output, 1: one-cycle strobe; `rx_data` is new.
- `tx_req`, output, 1: one-cycle strobe; user must present the next read byte.
- `tx_data`, input, 8: byte to return to the master on a read.
- `busy`, output, 1: high from address match until STOP or repeated START.

## Operation

- Synchronization: `SCL` and `SDA` each pass through a 2-flop synchronizer plus a history flop.
  - Edge events (scl_rise, scl_fall, sda_rise, sda_fall) are single-cycle pulses on synchronized values.
- START: sda_fall while synced SCL high. STOP: sda_rise while synced SCL high.
  - Both are recognized in every state and take priority over bit events in the same cycle.
- Data is sampled on scl_rise. SDA drive changes are applied on scl_fall.
- Shift register is 8 bits, MSB first. A 3-bit bit counter wraps from 7 to 0 at the byte boundary.
- State machine:
  - IDLE: SDA released. START → ADDR.
  - ADDR: shift 8 bits on scl_rise. After bit 8, compare bits[7:1] to `ADDR`.
    - Match → ADDR_ACK, with rw = bit[0] (1 = master reads).
    - Mismatch → WAIT_STOP.
  - ADDR_ACK: drive SDA low from the next scl_fall until the following scl_fall.
    - Then go to RD_DATA if rw=1, else WR_DATA.
    - `busy` sets on entry.
  - WR_DATA: shift 8 bits. On the 8th scl_rise: `rx_data` ← shift value, `rx_valid` pulses the same cycle, then go to WR_ACK.
  - WR_ACK: always ACK (SDA low for one SCL period, same timing as ADDR_ACK). Then WR_DATA.
  - RD_DATA: byte loaded from `tx_data` at the scl_fall ending the prior ACK.
    - Each scl_fall drives SDA = 0 for a 0 bit and releases SDA for a 1 bit.
    - After the 8th bit, release SDA at scl_fall and go to RD_ACK.
  - RD_ACK: sample master ACK on scl_rise.
    - SDA=0 (ACK) → pulse `tx_req`, return to RD_DATA.
    - SDA=1 (NACK) → WAIT_STOP, no `tx_req`.
  - WAIT_STOP: SDA released, bus ignored until STOP or START.
- `tx_req` also pulses on the scl_rise of the address ACK bit when rw=1.
  - `tx_data` is latched at the next scl_fall; user has ≥ half an SCL period to respond.
- STOP from any state → IDLE: SDA released, `busy`=0.
- START from any state (repeated START) → ADDR: SDA released, `busy`=0, bit counter cleared.
  - A partial write byte is discarded and `rx_valid` does not pulse.

## Timing

- Reset values:
  - Outputs: `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, SDA released (z).
  - Internal: state=IDLE. Synchronizers reset to 1 (idle bus) so no spurious edges appear after reset.
- Input latency: 2–3 `clk` from a bus pin change to the internal edge event.
- SDA drive changes occur 3 `clk` after the real SCL falling edge, giving ≥ 60 ns hold at 50 MHz.
- `rx_valid` asserts 3 `clk` after the 8th real SCL rising edge of a write byte.
- Reset asserted mid-transfer releases SDA immediately (asynchronously). The block then waits in IDLE for a fresh START.
- Address ACK is driven only on match. A general-call address (7'h00) is not acknowledged.

## Test plan

- Write 0x84 (ADDR 0x42, W), then data 0xA5, 0x3C, then STOP.
  - ACK low on all 3 ninth clocks.
  - `rx_valid` pulses twice, with `rx_data`=0xA5 then 0x3C.
  - `busy` falls after STOP.
- Read 0x85; user answers `tx_req` with 0x5A then 0xC3; master ACKs the first byte, NACKs the second, then STOP.
  - SDA carries 0x5A, 0xC3.
  - Exactly 2 `tx_req` pulses.
  - SDA released after the NACK.
- Address 0x90 (0x48, W) then data 0xFF.
  - No ACK (SDA stays z throughout).
  - No `rx_valid`; `busy`=0.
- Write 0x84, 4 bits of data, then repeated START, then 0x85 read.
  - No `rx_valid` for the partial byte.
  - Address re-ACKed and `tx_req` pulses.
- Assert `rst_n`=0 during the RD_DATA bit-3 low phase with SDA driven low.
  - SDA goes z within the same cycle; outputs return to reset values.
  - The next valid transaction completes normally.
- START immediately followed by STOP with no SCL pulses → state returns to IDLE, no outputs toggle.
